// File: rtl/ir_nec_encoder_if.sv
// Request channel of the NEC IR framer: one address/command (or repeat) per
// tx_valid && tx_ready handshake.
interface ir_nec_encoder_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_addr;
   logic [7:0] tx_cmd;
   logic       tx_repeat;

   modport master (
      output tx_valid,
      output tx_addr,
      output tx_cmd,
      output tx_repeat,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_addr,
      input  tx_cmd,
      input  tx_repeat,
      output tx_ready
   );
endinterface

// File: rtl/ir_nec_encoder.sv
// NEC IR transmit framer: turns one accepted address/command (or repeat request)
// into the mark/space envelope that gates the downstream 38 kHz carrier PWM.
module ir_nec_encoder #(
   parameter int F_CLK       = 100_000_000,
   parameter int UNIT_CYCLES = 56_250
) (
   input  logic              clk,
   input  logic              rst_n,
   ir_nec_encoder_if.slave   tx,
   output logic              carrier_en,
   output logic              busy,
   output logic              done
);

   localparam int            CW       = $clog2(UNIT_CYCLES);
   localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      REP_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK
   } state_t;

   state_t        state;
   logic [CW-1:0] cyc_cnt;
   logic [4:0]    unit_cnt;
   logic [4:0]    bit_idx;
   logic [31:0]   shift_reg;
   logic          repeat_q;
   logic [4:0]    unit_last;
   logic          state_end;

   // F_CLK only documents the clock the UNIT_CYCLES value was chosen for.
   wire unused_fclk = (F_CLK != 0);

   always_comb begin
      unit_last = 5'd0;
      case (state)
         LEAD_MARK:  unit_last = 5'd15;
         LEAD_SPACE: unit_last = 5'd7;
         REP_SPACE:  unit_last = 5'd3;
         BIT_SPACE:  unit_last = shift_reg[0] ? 5'd2 : 5'd0;
         default:    unit_last = 5'd0;
      endcase
   end

   assign state_end   = (cyc_cnt == CYC_LAST) && (unit_cnt == unit_last);
   assign tx.tx_ready = (state == IDLE);

   // Each state is left on the last cycle of its last unit, so consecutive
   // marks and spaces abut with no gap or overlap cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cyc_cnt    <= '0;
         unit_cnt   <= 5'd0;
         bit_idx    <= 5'd0;
         shift_reg  <= 32'd0;
         repeat_q   <= 1'b0;
         carrier_en <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (tx.tx_valid) begin
               shift_reg  <= {~tx.tx_cmd, tx.tx_cmd, ~tx.tx_addr, tx.tx_addr};
               repeat_q   <= tx.tx_repeat;
               state      <= LEAD_MARK;
               carrier_en <= 1'b1;
               busy       <= 1'b1;
               cyc_cnt    <= '0;
               unit_cnt   <= 5'd0;
               bit_idx    <= 5'd0;
            end
         end else if (state_end) begin
            cyc_cnt  <= '0;
            unit_cnt <= 5'd0;
            case (state)
               LEAD_MARK: begin
                  state      <= repeat_q ? REP_SPACE : LEAD_SPACE;
                  carrier_en <= 1'b0;
               end
               LEAD_SPACE: begin
                  state      <= BIT_MARK;
                  carrier_en <= 1'b1;
                  bit_idx    <= 5'd0;
               end
               REP_SPACE: begin
                  state      <= STOP_MARK;
                  carrier_en <= 1'b1;
               end
               BIT_MARK: begin
                  state      <= BIT_SPACE;
                  carrier_en <= 1'b0;
               end
               BIT_SPACE: begin
                  shift_reg  <= {1'b0, shift_reg[31:1]};
                  carrier_en <= 1'b1;
                  if (bit_idx == 5'd31) begin
                     state <= STOP_MARK;
                  end else begin
                     state   <= BIT_MARK;
                     bit_idx <= bit_idx + 5'd1;
                  end
               end
               STOP_MARK: begin
                  state      <= IDLE;
                  carrier_en <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end
               default: begin
                  state      <= IDLE;
                  carrier_en <= 1'b0;
                  busy       <= 1'b0;
               end
            endcase
         end else if (cyc_cnt == CYC_LAST) begin
            cyc_cnt  <= '0;
            unit_cnt <= unit_cnt + 5'd1;
         end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ir_nec_encoder.sv
// Randomized bench for ir_nec_encoder: frames are run-length decoded from
// carrier_en and compared against an envelope model built from NEC unit timing.
module tb_ir_nec_encoder;

   localparam int U = 4;

   logic clk;
   logic rst_n;
   logic carrier_en;
   logic busy;
   logic done;

   int checks;
   int fails;

   int exp_lvl[$];
   int exp_len[$];
   int act_lvl[$];
   int act_len[$];
   bit cap[$];

   ir_nec_encoder_if tx_bus();

   ir_nec_encoder #(
      .F_CLK      (100_000_000),
      .UNIT_CYCLES(U)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx        (tx_bus),
      .carrier_en(carrier_en),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // The 32 transmitted bits, addr byte first, each byte followed by its inverse.
   function automatic logic [31:0] frameWord(input logic [7:0] a, input logic [7:0] c);
      int w;
      w = int'(a) + (255 - int'(a)) * 256 + int'(c) * 65536 + (255 - int'(c)) * 16777216;
      return w;
   endfunction

   task automatic pushSeg(input int lvl, input int units);
      exp_lvl.push_back(lvl);
      exp_len.push_back(units * U);
   endtask

   task automatic buildModel(input logic [7:0] a, input logic [7:0] c, input bit rep);
      logic [31:0] w;
      exp_lvl.delete();
      exp_len.delete();
      pushSeg(1, 16);
      if (rep) begin
         pushSeg(0, 4);
      end else begin
         pushSeg(0, 8);
         w = frameWord(a, c);
         for (int i = 0; i < 32; i++) begin
            pushSeg(1, 1);
            pushSeg(0, ((w >> i) & 1) != 0 ? 3 : 1);
         end
      end
      pushSeg(1, 1);
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] c, input bit rep,
                                input bit keep_valid, input logic [7:0] na, input logic [7:0] nc,
                                input bit nrep);
      @(negedge clk);
      tx_bus.tx_valid  = 1'b1;
      tx_bus.tx_addr   = a;
      tx_bus.tx_cmd    = c;
      tx_bus.tx_repeat = rep;
      checkOutput("ready_before_accept", tx_bus.tx_ready, 1'b1);
      @(posedge clk);
      #1;
      tx_bus.tx_valid = keep_valid;
      if (keep_valid) begin
         tx_bus.tx_addr   = na;
         tx_bus.tx_cmd    = nc;
         tx_bus.tx_repeat = nrep;
      end else begin
         tx_bus.tx_addr   = 8'($urandom);
         tx_bus.tx_cmd    = 8'($urandom);
         tx_bus.tx_repeat = 1'($urandom);
      end
   endtask

   // Samples from the negedge after the accept edge up to and including the done cycle.
   task automatic checkFrame(input string name, input logic [7:0] a, input logic [7:0] c, input bit rep);
      int busy_cycles;
      int bad_busy;
      int total;
      bit ended;
      logic [31:0] word;
      buildModel(a, c, rep);
      cap.delete();
      busy_cycles = 0;
      bad_busy    = 0;
      ended       = 1'b0;
      for (int n = 0; n < 1000 && !ended; n++) begin
         @(negedge clk);
         if (busy) begin
            cap.push_back(carrier_en);
            busy_cycles++;
            if (done || tx_bus.tx_ready) bad_busy++;
         end else begin
            ended = 1'b1;
            checkOutput({name, "_done_pulse"}, done, 1'b1);
            checkOutput({name, "_idle_carrier"}, carrier_en, 1'b0);
            checkOutput({name, "_idle_ready"}, tx_bus.tx_ready, 1'b1);
         end
      end
      checkOutput({name, "_frame_end"}, ended, 1'b1);
      checkOutput({name, "_busy_flags"}, bad_busy, 0);
      total = rep ? 21 * U : 121 * U;
      checkOutput({name, "_busy_cycles"}, busy_cycles, total);

      act_lvl.delete();
      act_len.delete();
      foreach (cap[i]) begin
         if (act_len.size() > 0 && act_lvl[act_lvl.size()-1] == int'(cap[i]))
            act_len[act_len.size()-1] += 1;
         else begin
            act_lvl.push_back(int'(cap[i]));
            act_len.push_back(1);
         end
      end
      checkOutput({name, "_seg_count"}, act_len.size(), exp_len.size());
      for (int i = 0; i < exp_len.size() && i < act_len.size(); i++)
         checkOutput($sformatf("%s_seg%0d", name, i),
                     act_lvl[i] * 65536 + act_len[i], exp_lvl[i] * 65536 + exp_len[i]);

      if (!rep && act_len.size() >= 67) begin
         word = 32'd0;
         for (int i = 0; i < 32; i++)
            if (act_len[3 + 2 * i] > 2 * U) word = word | (32'd1 << i);
         checkOutput({name, "_decoded"}, word, frameWord(a, c));
      end
   endtask

   task automatic checkDoneDrops(input string name);
      @(negedge clk);
      checkOutput({name, "_done_width"}, done, 1'b0);
      checkOutput({name, "_ready_after"}, tx_bus.tx_ready, 1'b1);
   endtask

   initial begin
      logic [7:0] a, c, a2, c2;
      bit         rep;
      int         to_space;
      checks = 0;
      fails  = 0;

      rst_n            = 1'b0;
      tx_bus.tx_valid  = 1'b1;
      tx_bus.tx_addr   = 8'($urandom);
      tx_bus.tx_cmd    = 8'($urandom);
      tx_bus.tx_repeat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("reset_carrier", carrier_en, 1'b0);
         checkOutput("reset_busy", busy, 1'b0);
         checkOutput("reset_done", done, 1'b0);
         checkOutput("reset_ready", tx_bus.tx_ready, 1'b1);
      end
      tx_bus.tx_valid = 1'b0;
      rst_n           = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("post_reset_busy", busy, 1'b0);
      checkOutput("post_reset_ready", tx_bus.tx_ready, 1'b1);

      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      checkFrame("zero", 8'h00, 8'h00, 1'b0);
      checkDoneDrops("zero");

      applyStimulus(8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      checkFrame("a5_3c", 8'hA5, 8'h3C, 1'b0);
      checkDoneDrops("a5_3c");

      for (int k = 0; k < 6; k++) begin
         a   = 8'($urandom);
         c   = 8'($urandom);
         rep = (k % 3 == 2);
         applyStimulus(a, c, rep, 1'b0, 8'h00, 8'h00, 1'b0);
         checkFrame(rep ? $sformatf("rand%0d_rep", k) : $sformatf("rand%0d", k), a, c, rep);
         checkDoneDrops($sformatf("rand%0d", k));
      end

      // tx_valid stays high with new fields through the whole first frame.
      a  = 8'($urandom);
      c  = 8'($urandom);
      a2 = 8'($urandom);
      c2 = 8'($urandom);
      applyStimulus(a, c, 1'b0, 1'b1, a2, c2, 1'b0);
      checkFrame("b2b_first", a, c, 1'b0);
      @(posedge clk);
      #1;
      tx_bus.tx_valid = 1'b0;
      tx_bus.tx_addr  = 8'($urandom);
      tx_bus.tx_cmd   = 8'($urandom);
      checkFrame("b2b_second", a2, c2, 1'b0);
      checkDoneDrops("b2b_second");

      // Abort inside the space of bit 10.
      a = 8'($urandom);
      c = 8'($urandom);
      applyStimulus(a, c, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      buildModel(a, c, 1'b0);
      to_space = 0;
      for (int i = 0; i <= 22; i++) to_space += exp_len[i];
      repeat (to_space + 2) @(negedge clk);
      checkOutput("abort_in_space_carrier", carrier_en, 1'b0);
      checkOutput("abort_in_space_busy", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_carrier", carrier_en, 1'b0);
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_ready", tx_bus.tx_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("abort_no_done", done, 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("abort_release_done", done, 1'b0);
      checkOutput("abort_release_busy", busy, 1'b0);

      a = 8'($urandom);
      c = 8'($urandom);
      applyStimulus(a, c, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      checkFrame("after_abort", a, c, 1'b0);
      checkDoneDrops("after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
